// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: safety checker for the 4-way light bus.
// Tracks the NS_G/NS_Y/WE_G/WE_Y sequence and latches the first fault.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   n/s/e/w_light [2:0]   light codes (001 G, 010 R, 100 Y)
//   clr                   sync fault clear / resync
//   phase [2:0]           0 SYNC,1 NS_G,2 NS_Y,3 WE_G,4 WE_Y,7 FAULT
//   fault                 sticky fault flag
//   fault_code [2:0]      cause of first fault
//   phase_done            1-cycle pulse on a legal phase end
//   err_cnt [7:0]         saturating count of FAULT entries
//
// Build option: define MONITOR_TIMING_EN to enable the dwell
// counter and dwell-error code 5.

module traffic_light_monitor #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] n_light,
  input  logic [2:0] s_light,
  input  logic [2:0] e_light,
  input  logic [2:0] w_light,
  input  logic       clr,
  output logic [2:0] phase,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       phase_done,
  output logic [7:0] err_cnt
);

  localparam logic [2:0] ST_SYNC  = 3'd0;
  localparam logic [2:0] ST_NSG   = 3'd1;
  localparam logic [2:0] ST_NSY   = 3'd2;
  localparam logic [2:0] ST_WEG   = 3'd3;
  localparam logic [2:0] ST_WEY   = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd7;

  localparam logic [2:0] L_GREEN  = 3'b001;
  localparam logic [2:0] L_RED    = 3'b010;
  localparam logic [2:0] L_YEL    = 3'b100;

  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_CODE  = 3'd1;
  localparam logic [2:0] FC_PAIR  = 3'd2;
  localparam logic [2:0] FC_CONF  = 3'd3;
  localparam logic [2:0] FC_ORDER = 3'd4;
  localparam logic [2:0] FC_DWELL = 3'd5;
  localparam logic [2:0] FC_ALLRD = 3'd6;

  if (GREEN_CYC  >= (2 ** CNT_W) ||
      YELLOW_CYC >= (2 ** CNT_W))
  begin : g_cfg_chk
    $error("dwell limits do not fit CNT_W");
  end

  function automatic logic code_ok(
    input logic [2:0] c
  );
    return (c == L_GREEN) ||
           (c == L_RED)   ||
           (c == L_YEL);
  endfunction

  logic bad_code;
  logic bad_pair;
  logic ns_red;
  logic we_red;
  logic conflict;
  logic all_red;

  assign bad_code = !(code_ok(n_light) &&
                      code_ok(s_light) &&
                      code_ok(e_light) &&
                      code_ok(w_light));

  assign bad_pair = (n_light != s_light) ||
                    (e_light != w_light);

  assign ns_red   = (n_light == L_RED);
  assign we_red   = (e_light == L_RED);
  assign conflict = !ns_red && !we_red;
  assign all_red  = ns_red && we_red;

  logic is_nsg;
  logic is_nsy;
  logic is_weg;
  logic is_wey;

  assign is_nsg = (n_light == L_GREEN) &&
                  (s_light == L_GREEN) &&
                  (e_light == L_RED)   &&
                  (w_light == L_RED);

  assign is_nsy = (n_light == L_YEL) &&
                  (s_light == L_YEL) &&
                  (e_light == L_RED) &&
                  (w_light == L_RED);

  assign is_weg = (e_light == L_GREEN) &&
                  (w_light == L_GREEN) &&
                  (n_light == L_RED)   &&
                  (s_light == L_RED);

  assign is_wey = (e_light == L_YEL) &&
                  (w_light == L_YEL) &&
                  (n_light == L_RED) &&
                  (s_light == L_RED);

  // Sample pattern as a phase number;
  // SYNC means "not a legal pattern".
  logic [2:0] pat_st;

  always_comb begin
    pat_st = ST_SYNC;
    unique case (1'b1)
      is_nsg:  pat_st = ST_NSG;
      is_nsy:  pat_st = ST_NSY;
      is_weg:  pat_st = ST_WEG;
      is_wey:  pat_st = ST_WEY;
      default: pat_st = ST_SYNC;
    endcase
  end

  logic [2:0] nxt_st;

  always_comb begin
    nxt_st = ST_FAULT;
    unique case (phase)
      ST_NSG:  nxt_st = ST_NSY;
      ST_NSY:  nxt_st = ST_WEG;
      ST_WEG:  nxt_st = ST_WEY;
      ST_WEY:  nxt_st = ST_NSG;
      default: nxt_st = ST_FAULT;
    endcase
  end

  logic hold;
  logic adv;

  assign hold = (pat_st == phase);
  assign adv  = (pat_st == nxt_st);

  logic dwell_err;
  logic done_ok;

`ifdef MONITOR_TIMING_EN

  localparam logic [CNT_W-1:0] G_LIM =
    CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] Y_LIM =
    CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] lim;
  // First phase after SYNC: its start was
  // not observed, so no short-dwell check.
  logic             first;

  assign lim = ((phase == ST_NSG) ||
                (phase == ST_WEG)) ? G_LIM : Y_LIM;

  always_comb begin
    dwell_err = 1'b0;
    if (hold)
      dwell_err = (dwell == lim);
    else if (adv)
      dwell_err = !first && (dwell != lim);
  end

  assign done_ok = !first;

`else

  assign dwell_err = 1'b0;
  assign done_ok   = 1'b1;

`endif

  logic [2:0] code;

  always_comb begin
    code = FC_NONE;
    if (bad_code)
      code = FC_CODE;
    else if (bad_pair)
      code = FC_PAIR;
    else if (conflict)
      code = FC_CONF;
    else if (all_red)
      code = FC_ALLRD;
    else if (phase == ST_SYNC)
      code = FC_NONE;
    else if (!hold && !adv)
      code = FC_ORDER;
    else if (dwell_err)
      code = FC_DWELL;
  end

  logic take;
  logic trip;
  logic accept;

  assign take   = !clr && (phase != ST_FAULT);
  assign trip   = take && (code != FC_NONE);
  assign accept = take && (code == FC_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= ST_SYNC;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      phase_done <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      phase_done <= 1'b0;
      if (clr) begin
        phase      <= ST_SYNC;
        fault      <= 1'b0;
        fault_code <= FC_NONE;
      end else if (trip) begin
        phase      <= ST_FAULT;
        fault      <= 1'b1;
        fault_code <= code;
        if (err_cnt != 8'hff)
          err_cnt <= err_cnt + 8'd1;
      end else if (accept) begin
        if (phase == ST_SYNC) begin
          phase <= pat_st;
        end else if (adv) begin
          phase      <= pat_st;
          phase_done <= done_ok;
        end
      end
    end
  end

`ifdef MONITOR_TIMING_EN

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      first <= 1'b0;
    end else if (clr) begin
      dwell <= '0;
      first <= 1'b0;
    end else if (accept) begin
      if (phase == ST_SYNC) begin
        dwell <= ONE;
        first <= 1'b1;
      end else if (hold) begin
        if (dwell != '1)
          dwell <= dwell + ONE;
      end else if (adv) begin
        dwell <= ONE;
        first <= 1'b0;
      end
    end
  end

`endif

endmodule
